tx_scheduler: RTL and testbench

- Owns the single outbound 40-bit packet path (OpEncoder/Sender) on the monitor link.
- Shares that path between three requesters: power-on reply, audio-refill request (from I2SSender), keyboard/mouse event.
- Enforces a minimum inter-packet gap and allows only one outstanding audio request at a time, with a timeout.
- Sits between the OpDecoder/I2SSender outputs and the Sender input in nextasic, clocked by mon_clk.

---
 rtl/nextasic_pkg.sv | 28 ++
 rtl/audio_req_tracker.sv | 47 ++++
 rtl/tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_tx_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nextasic_pkg.sv
// Shared definitions for the nextasic monitor-link logic.
//   - Opcode bytes that lead each outbound 40-bit packet word.
//   - Grant encodings reported by tx_scheduler.
//   - tx_scheduler FSM state encoding.
package nextasic_pkg;

  localparam logic [7:0] OP_POWER_ON  = 8'hC0;
  localparam logic [7:0] OP_AUDIO_REQ = 8'h07;
  localparam logic [7:0] OP_KM_DATA   = 8'hC5;

  typedef enum logic [1:0] {
    GR_NONE  = 2'd0,
    GR_POWER = 2'd1,
    GR_AUDIO = 2'd2,
    GR_KM    = 2'd3
  } grant_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [39:0] mk_word(input logic [7:0] op, input logic [31:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/audio_req_tracker.sv
// Tracks whether an audio-refill request is in flight.
//   i_clk         : monitor link clock
//   i_rst_n       : asynchronous active-low reset
//   i_set         : audio request word accepted by the Sender (wins over clear)
//   i_rcvd        : audio packet received pulse
//   o_outstanding : request sent, reply not yet seen and not yet timed out
module audio_req_tracker
  import nextasic_pkg::*;
#(
  parameter int unsigned AUDIO_TIMEOUT = 4096,
  parameter int unsigned CNT_W         = 13
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_rcvd,
  output logic o_outstanding
);

  logic             r_outstanding;
  logic [CNT_W-1:0] r_cnt;
  logic             w_expire;

  // Flag drops on the edge where the counter already reads AUDIO_TIMEOUT-1,
  // i.e. exactly AUDIO_TIMEOUT cycles after the accepting edge.
  assign w_expire = (r_cnt == CNT_W'(AUDIO_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outstanding <= 1'b0;
      r_cnt         <= '0;
    end else if (i_set) begin
      r_outstanding <= 1'b1;
      r_cnt         <= '0;
    end else if (r_outstanding) begin
      if (i_rcvd || w_expire) begin
        r_outstanding <= 1'b0;
        r_cnt         <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_outstanding = r_outstanding;

endmodule

// File: rtl/tx_scheduler.sv
// Shares the single outbound 40-bit packet path between the power-on reply,
// the audio-refill request and keyboard/mouse events, with a minimum gap
// between words and at most one outstanding audio request.
//   mon_clk, rst_n       : clock, asynchronous active-low reset
//   power_on_pulse       : power-on packet decoded (one cycle)
//   audio_req            : audio buffer wants refill (level)
//   audio_rcvd           : audio packet received (one cycle)
//   km_valid / km_data   : keyboard/mouse event and payload
//   km_ready             : km event consumed (pulse on the accept cycle)
//   sender_ready         : Sender can take a word
//   out_data / out_valid : word to Sender, held until accepted
//   audio_outstanding    : audio request in flight
//   grant                : current/last source (0 none, 1 power, 2 audio, 3 km)
module tx_scheduler
  import nextasic_pkg::*;
#(
  parameter int unsigned MIN_GAP       = 4,
  parameter int unsigned AUDIO_TIMEOUT = 4096,
  parameter int unsigned CNT_W         = 13
) (
  input  logic        mon_clk,
  input  logic        rst_n,
  input  logic        power_on_pulse,
  input  logic        audio_req,
  input  logic        audio_rcvd,
  input  logic        km_valid,
  input  logic [31:0] km_data,
  output logic        km_ready,
  input  logic        sender_ready,
  output logic [39:0] out_data,
  output logic        out_valid,
  output logic        audio_outstanding,
  output logic [1:0]  grant
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP - 1);

  state_e           r_state, w_state_nxt;
  logic [39:0]      r_out_data, w_data_nxt;
  logic             r_out_valid, w_valid_nxt;
  grant_e           r_grant, w_grant_nxt, w_pick;
  logic             r_power_pend, w_pend_nxt;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_nxt;
  logic             r_rr_km, w_rr_nxt;
  logic             w_accept, w_audio_set;
  logic             w_elig_audio;
  logic             w_outstanding;

  assign w_accept     = r_out_valid & sender_ready;
  assign w_elig_audio = audio_req & ~w_outstanding;

  audio_req_tracker #(
    .AUDIO_TIMEOUT(AUDIO_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_audio_trk (
    .i_clk        (mon_clk),
    .i_rst_n      (rst_n),
    .i_set        (w_audio_set),
    .i_rcvd       (audio_rcvd),
    .o_outstanding(w_outstanding)
  );

  // A new pulse on the accepting edge re-arms the pending power reply.
  assign w_pend_nxt = power_on_pulse |
                      (r_power_pend & ~(w_accept & (r_grant == GR_POWER)));

  always_comb begin
    w_pick = GR_NONE;
    if (r_power_pend) begin
      w_pick = GR_POWER;
    end else if (w_elig_audio && km_valid) begin
      w_pick = r_rr_km ? GR_KM : GR_AUDIO;
    end else if (w_elig_audio) begin
      w_pick = GR_AUDIO;
    end else if (km_valid) begin
      w_pick = GR_KM;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_out_data;
    w_valid_nxt = r_out_valid;
    w_grant_nxt = r_grant;
    w_gap_nxt   = r_gap_cnt;
    w_rr_nxt    = r_rr_km;
    w_audio_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick != GR_NONE) begin
          w_state_nxt = SEND;
          w_valid_nxt = 1'b1;
          w_grant_nxt = w_pick;
          case (w_pick)
            GR_POWER: w_data_nxt = mk_word(OP_POWER_ON, '0);
            GR_AUDIO: w_data_nxt = mk_word(OP_AUDIO_REQ, '0);
            default:  w_data_nxt = mk_word(OP_KM_DATA, km_data);
          endcase
        end
      end
      SEND: begin
        if (w_accept) begin
          w_valid_nxt = 1'b0;
          w_gap_nxt   = GAP_LOAD;
          // The IDLE cycle that follows GAP is the last gap cycle, so GAP
          // itself lasts MIN_GAP-1 cycles and is skipped when MIN_GAP is 1.
          w_state_nxt = (MIN_GAP > 1) ? GAP : IDLE;
          if (r_grant == GR_AUDIO) begin
            w_audio_set = 1'b1;
            w_rr_nxt    = 1'b1;
          end else if (r_grant == GR_KM) begin
            w_rr_nxt = 1'b0;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt <= CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_grant      <= GR_NONE;
      r_power_pend <= 1'b0;
      r_gap_cnt    <= '0;
      r_rr_km      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_out_data   <= w_data_nxt;
      r_out_valid  <= w_valid_nxt;
      r_grant      <= w_grant_nxt;
      r_power_pend <= w_pend_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_rr_km      <= w_rr_nxt;
    end
  end

  assign km_ready          = w_accept & (r_grant == GR_KM);
  assign out_data          = r_out_data;
  assign out_valid         = r_out_valid;
  assign audio_outstanding = w_outstanding;
  assign grant             = r_grant;

endmodule

// File: tb/tb_tx_scheduler.sv
module tb_tx_scheduler;

  localparam int unsigned MIN_GAP       = 4;
  localparam int unsigned AUDIO_TIMEOUT = 16;

  logic        mon_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        power_on_pulse = 1'b0;
  logic        audio_req = 1'b0;
  logic        audio_rcvd = 1'b0;
  logic        km_valid = 1'b0;
  logic [31:0] km_data = '0;
  logic        sender_ready = 1'b0;
  logic        km_ready;
  logic [39:0] out_data;
  logic        out_valid;
  logic        audio_outstanding;
  logic [1:0]  grant;

  tx_scheduler #(
    .MIN_GAP      (MIN_GAP),
    .AUDIO_TIMEOUT(AUDIO_TIMEOUT),
    .CNT_W        (13)
  ) dut (
    .mon_clk          (mon_clk),
    .rst_n            (rst_n),
    .power_on_pulse   (power_on_pulse),
    .audio_req        (audio_req),
    .audio_rcvd       (audio_rcvd),
    .km_valid         (km_valid),
    .km_data          (km_data),
    .km_ready         (km_ready),
    .sender_ready     (sender_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .audio_outstanding(audio_outstanding),
    .grant            (grant)
  );

  always #5 mon_clk = ~mon_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned km_pulses = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (timestamp based) ----------------
  int unsigned m_cyc = 0;
  bit          m_valid;
  logic [39:0] m_data;
  logic [1:0]  m_grant;
  bit          m_pend, m_outst, m_prefer_km;
  int unsigned m_deadline, m_next_ok;

  always @(posedge mon_clk) m_cyc <= m_cyc + 1;

  always @(posedge mon_clk or negedge rst_n) begin : model
    bit acc, ea, ek;
    logic [1:0] pick;
    if (!rst_n) begin
      m_valid <= 0; m_data <= '0; m_grant <= 2'd0; m_pend <= 0; m_outst <= 0;
      m_prefer_km <= 0; m_deadline <= 0; m_next_ok <= 0;
    end else begin
      acc = m_valid && sender_ready;
      m_pend <= power_on_pulse || (m_pend && !(acc && m_grant == 2'd1));
      if (acc && m_grant == 2'd2) begin
        m_outst    <= 1;
        m_deadline <= m_cyc + AUDIO_TIMEOUT;
      end else if (m_outst && (audio_rcvd || m_cyc == m_deadline)) begin
        m_outst <= 0;
      end
      if (m_valid) begin
        if (acc) begin
          m_valid   <= 0;
          m_next_ok <= m_cyc + MIN_GAP;
          if (m_grant == 2'd2) m_prefer_km <= 1;
          else if (m_grant == 2'd3) m_prefer_km <= 0;
        end
      end else if (m_cyc >= m_next_ok) begin
        ea = audio_req && !m_outst;
        ek = km_valid;
        if (m_pend) pick = 2'd1;
        else if (ea && ek) pick = m_prefer_km ? 2'd3 : 2'd2;
        else if (ea) pick = 2'd2;
        else if (ek) pick = 2'd3;
        else pick = 2'd0;
        if (pick != 2'd0) begin
          m_valid <= 1;
          m_grant <= pick;
          m_data  <= (pick == 2'd1) ? {8'hC0, 32'h0} :
                     (pick == 2'd2) ? {8'h07, 32'h0} : {8'hC5, km_data};
        end
      end
    end
  end

  always @(negedge mon_clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, m_valid);
      check("out_data", out_data, m_data);
      check("grant", grant, m_grant);
      check("audio_outstanding", audio_outstanding, m_outst);
      check("km_ready", km_ready, m_valid && sender_ready && m_grant == 2'd3);
    end
    if (km_ready === 1'b1) km_pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge mon_clk);
    #1;
  endtask

  task automatic clr_inputs;
    power_on_pulse = 0; audio_req = 0; audio_rcvd = 0;
    km_valid = 0; km_data = '0; sender_ready = 0;
  endtask

  task automatic do_reset;
    clr_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic wait_valid(output int k, input int budget);
    k = 0;
    while (out_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (out_valid !== 1'b1) check("wait_valid_timeout", out_valid, 1);
  endtask

  initial begin
    int k, nv;
    int unsigned p0;
    #1;
    chk_en = 1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_grant", grant, 0);
    check("rst_outstanding", audio_outstanding, 0);
    check("rst_km_ready", km_ready, 0);
    tick(); tick();
    rst_n = 1;

    // audio request, one outstanding at a time
    audio_req = 1; sender_ready = 1;
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 40'h07_0000_0000);
    check("t1_grant", grant, 2);
    tick();
    check("t1_valid_low", out_valid, 0);
    check("t1_outstanding", audio_outstanding, 1);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) nv++;
    end
    check("t1_no_reissue", nv, 0);
    audio_rcvd = 1; tick(); audio_rcvd = 0;
    check("t1_rcvd_clears", audio_outstanding, 0);
    wait_valid(k, 20);
    check("t1_reissue_lat", k, 1);
    check("t1_reissue_data", out_data, 40'h07_0000_0000);

    // km held under back-pressure, power pending behind it
    do_reset();
    km_valid = 1; km_data = 32'h1234_5678; sender_ready = 0;
    tick();
    check("t2_km_data", out_data, 40'hC5_1234_5678);
    check("t2_km_grant", grant, 3);
    power_on_pulse = 1; tick(); power_on_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold", {out_valid, out_data[38:0]}, {1'b1, 39'h45_1234_5678});
    end
    sender_ready = 1;
    #1;
    check("t2_km_ready", km_ready, 1);
    tick();
    wait_valid(k, 20);
    check("t2_gap_len", k, 4);
    check("t2_power_data", out_data, 40'hC0_0000_0000);
    check("t2_power_grant", grant, 1);
    tick();

    // round-robin between audio and km
    do_reset();
    audio_req = 1; km_valid = 1; km_data = 32'hDEAD_BEEF; sender_ready = 1;
    p0 = km_pulses;
    for (int w = 0; w < 6; w++) begin
      wait_valid(k, 40);
      check("t3_word", out_data, (w % 2 == 0) ? 40'h07_0000_0000 : 40'hC5_DEAD_BEEF);
      tick();
      if (w % 2 == 0) begin
        audio_rcvd = 1; tick(); audio_rcvd = 0;
      end
    end
    check("t3_km_pulses", km_pulses - p0, 3);

    // audio timeout
    do_reset();
    audio_req = 1; sender_ready = 1;
    wait_valid(k, 10);
    tick();
    k = 0;
    while (audio_outstanding === 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("t4_timeout_len", k, 16);
    tick();
    check("t4_reissue", {out_valid, out_data}, {1'b1, 40'h07_0000_0000});

    // reset while a km word is on offer
    do_reset();
    km_valid = 1; km_data = 32'hCAFE_F00D; sender_ready = 0;
    tick();
    check("t5_valid", out_valid, 1);
    p0 = km_pulses;
    #2;
    rst_n = 0;
    #1;
    check("t5_async_valid", out_valid, 0);
    sender_ready = 1;
    #1;
    check("t5_no_km_ready", km_ready, 0);
    tick(); tick();
    rst_n = 1;
    check("t5_pulses_in_reset", km_pulses - p0, 0);
    tick();
    check("t5_resend", {out_valid, out_data}, {1'b1, 40'hC5_CAFE_F00D});
    check("t5_grant", grant, 3);
    tick();
    km_valid = 0;
    check("t5_one_pulse", km_pulses - p0, 1);

    // power pulse coincident with power accept
    do_reset();
    power_on_pulse = 1; tick(); power_on_pulse = 0;
    tick();
    check("t6_power1", {out_valid, out_data}, {1'b1, 40'hC0_0000_0000});
    sender_ready = 1; power_on_pulse = 1;
    tick();
    power_on_pulse = 0;
    wait_valid(k, 20);
    check("t6_gap_len", k, 4);
    check("t6_power2", out_data, 40'hC0_0000_0000);
    tick();
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid === 1'b1) nv++;
    end
    check("t6_no_third", nv, 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      sender_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) audio_req = ~audio_req;
      audio_rcvd     = ($urandom_range(0, 7) == 0);
      power_on_pulse = ($urandom_range(0, 63) == 0);
      if (!km_valid) begin
        if ($urandom_range(0, 3) == 0) begin
          km_valid = 1;
          km_data  = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        km_valid = 0;
      end
      tick();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
